// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I decode/control stage: opcodes, ALU encodings
// and the decoded control bundle carried into the ID/EX register.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        alu_src_b;
    logic        alu_src_a_pc;
    logic        illegal;
    alu_ctrl_t   alu_ctrl;
    result_src_t result_src;
    logic [2:0]  funct3;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = ctrl_bundle_t'('0);

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful
  function automatic alu_ctrl_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_instr_decoder.sv
// Combinational RV32I decoder: instruction word to control bundle plus
// source-register usage flags for hazard detection.
module rv_instr_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         rs1_used,
  output logic         rs2_used
);

  logic [6:0] opcode, funct7;
  logic [2:0] f3;
  logic       bad;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl     = CTRL_NOP;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    bad      = 1'b0;
    case (opcode)
      OP_R: begin
        bad = !(funct7 == 7'h00 || (funct7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_from_f3(f3, funct7[5]);
        ctrl.funct3    = f3;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_IMM: begin
        bad = (f3 == 3'd1 && funct7 != 7'h00) ||
              (f3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20);
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = alu_from_f3(f3, f3 == 3'd5 && funct7[5]);
        ctrl.funct3    = f3;
        rs1_used = 1'b1;
      end
      OP_LOAD: begin
        bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.funct3     = f3;
        rs1_used = 1'b1;
      end
      OP_STORE: begin
        bad = (f3 > 3'd2);
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.funct3    = f3;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_BRANCH: begin
        bad = (f3 == 3'd2 || f3 == 3'd3);
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.funct3   = f3;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
      end
      OP_AUIPC: begin
        ctrl.reg_write    = 1'b1;
        ctrl.alu_src_b    = 1'b1;
        ctrl.alu_src_a_pc = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jal        = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        bad = (f3 != 3'd0);
        ctrl.reg_write  = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_PC4;
        rs1_used = 1'b1;
      end
      OP_FENCE: begin
        bad = (f3 != 3'd0);
        rs1_used = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // Illegal encodings must not write anything nor create a hazard
    if (bad) begin
      ctrl         = CTRL_NOP;
      ctrl.illegal = 1'b1;
      rs1_used     = 1'b0;
      rs2_used     = 1'b0;
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// RV32I decode/control stage: decode, load-use hazard bubble, flush and
// back-pressure handling into the ID/EX register, plus stall/flush counters.
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [XLEN-1:0]  id_pc,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             stall_if,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_jal,
  output logic             ex_jalr,
  output logic             ex_alu_src_b,
  output logic             ex_alu_src_a_pc,
  output logic             ex_illegal,
  output logic [3:0]       ex_alu_ctrl,
  output logic [1:0]       ex_result_src,
  output logic [2:0]       ex_funct3,
  output logic [RA_W-1:0]  ex_rd,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [XLEN-1:0]  ex_pc,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_bundle_t    dec, ex_ctrl;
  logic            rs1_used, rs2_used, hazard;
  logic            load_bubble, load_id;
  logic [RA_W-1:0] id_rd, id_rs1, id_rs2;

  rv_instr_decoder u_dec (
    .instr    (id_instr),
    .ctrl     (dec),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign id_rd  = RA_W'(id_instr[11:7]);
  assign id_rs1 = RA_W'(id_instr[19:15]);
  assign id_rs2 = RA_W'(id_instr[24:20]);

  assign hazard = id_valid && ex_valid && ex_ctrl.mem_read && (ex_rd != '0) &&
                  ((rs1_used && ex_rd == id_rs1) || (rs2_used && ex_rd == id_rs2));

  // Gated by rst so the stage presents all-zero outputs while held in reset
  assign stall_if = !rst && !flush && (!ex_ready || hazard);

  // flush > !ex_ready (hold) > hazard > normal; an idle ID also loads a bubble
  assign load_bubble = flush || (ex_ready && (hazard || !id_valid));
  assign load_id     = !flush && ex_ready && !hazard && id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
      ex_rd    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_pc    <= '0;
    end else if (load_bubble) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
      ex_rd    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_pc    <= '0;
    end else if (load_id) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= dec;
      ex_rd    <= id_rd;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_pc    <= id_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
      if (!flush && ex_ready && hazard && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

  assign ex_reg_write    = ex_ctrl.reg_write;
  assign ex_mem_read     = ex_ctrl.mem_read;
  assign ex_mem_write    = ex_ctrl.mem_write;
  assign ex_branch       = ex_ctrl.branch;
  assign ex_jal          = ex_ctrl.jal;
  assign ex_jalr         = ex_ctrl.jalr;
  assign ex_alu_src_b    = ex_ctrl.alu_src_b;
  assign ex_alu_src_a_pc = ex_ctrl.alu_src_a_pc;
  assign ex_illegal      = ex_ctrl.illegal;
  assign ex_alu_ctrl     = ex_ctrl.alu_ctrl;
  assign ex_result_src   = ex_ctrl.result_src;
  assign ex_funct3       = ex_ctrl.funct3;

endmodule
